snake_dir_ctrl: RTL and testbench
=================================

Name: snake_dir_ctrl

Overview:
Input-conditioning stage directly upstream of the snake game logic. Takes the four raw board switches, then synchronises, debounces and edge-detects them. Valid turn requests go into a 2-deep turn queue, and the queue releases one turn per game-step tick. The block drives the one-hot Up/Down/Left/Right direction lines consumed by the snake logic, so fast double-turns between steps are kept and the snake never reverses into itself.

Parameters:
DEBOUNCE_LIMIT, 250000, stable cycles required before a switch change is accepted (10 ms at 25 MHz; bench uses 4).
CNT_WIDTH, 18, width of each debounce counter; must hold DEBOUNCE_LIMIT-1.
INIT_DIR, 2'b11, direction loaded at reset (00 up, 01 down, 10 left, 11 right).

Ports:
i_Clk  input  1  pixel/system clock.
Reset  input  1  synchronous, active-high reset.
i_Sw  input  4  raw switches: [3] up, [0] down, [1] left, [2] right; active-high, asynchronous to i_Clk.
i_Tick  input  1  one-cycle game-step pulse, synchronous to i_Clk.
o_Dir  output  2  current committed direction (encoding as INIT_DIR).
o_Snake_Up / o_Snake_Down / o_Snake_Left / o_Snake_Right  output  1 each  one-hot decode of o_Dir.
o_Sw_Debounced  output  4  debounced switch levels.
o_Queue_Count  output  2  pending turns (0..2).
o_Turn_Drop  output  1  one-cycle pulse when an accepted-direction press is lost because the queue is full.

Behaviour:
- Reset (synchronous, any cycle, including mid-debounce or with a full queue):
  - o_Dir=INIT_DIR; one-hot outputs follow o_Dir (right=1, others 0 for the default).
  - Sync flops, debounced levels, counters, queue and o_Queue_Count all clear to 0; o_Turn_Drop=0.
- Synchroniser: two flops per switch.
- Debounce, per switch, independently:
  - When the synced level differs from the debounced level, the counter increments.
  - When the synced level equals the debounced level, the counter clears.
  - On the cycle the counter equals DEBOUNCE_LIMIT-1 with a mismatch, the debounced level takes the synced value and the counter clears.
  - Net latency: a clean input edge appears on o_Sw_Debounced DEBOUNCE_LIMIT+2 cycles later.
  - Any bounce shorter than DEBOUNCE_LIMIT cycles produces no change.
- Press detect:
  - A press is a 0->1 transition of a debounced level.
  - Release edges are ignored.
  - Several presses in one cycle: only the highest priority is taken, Up > Down > Left > Right; the rest are discarded with no drop pulse.
- Request filter:
  - Reference direction = queue tail if o_Queue_Count>0, else o_Dir.
  - A press equal to the reference, or the opposite of it (up/down, left/right), is rejected silently.
  - Otherwise it is accepted.
- Queue, 2-entry FIFO:
  - An accepted press pushes; the queue is visible one cycle after the press (DEBOUNCE_LIMIT+3 cycles after the input edge).
  - i_Tick with count>0 pops the head into o_Dir; o_Dir changes on the cycle after the tick.
  - i_Tick with count=0 leaves o_Dir unchanged.
- Simultaneous push and pop:
  - Pop and push both occur and the count is unchanged.
  - The filter reference is still the pre-pop tail (or o_Dir if count was 0; the pushed entry then stays queued).
  - With count=2 the push is accepted, because the pop frees the slot.
- Full queue, accepted press, no tick: the press is dropped and o_Turn_Drop pulses for exactly 1 cycle; queue and o_Dir are unchanged.
- Count arithmetic saturates within 0..2; it never wraps.
- Outputs are registered except the one-hot decode of o_Dir, which is combinational.

Test Plan:
1. Reset values: assert Reset 3 cycles -> o_Dir=11, o_Snake_Right=1 with the other three 0, o_Queue_Count=0, o_Sw_Debounced=0000, o_Turn_Drop=0.
2. Debounce (LIMIT=4):
   - Toggle i_Sw[3] every 2 cycles for 20 cycles, then hold 1 -> o_Sw_Debounced[3] rises exactly once, 6 cycles after the final edge.
   - Exactly one push occurs: count=1.
3. Reversal reject, from reset (right):
   - Press left -> count stays 0, no drop.
   - Press up -> count=1; pulse i_Tick -> o_Dir=00 the next cycle, count=0.
4. Queue and overflow, from right:
   - Press up, then left -> count=2.
   - Press down -> o_Turn_Drop pulses 1 cycle, count stays 2.
   - Tick -> o_Dir=00; tick -> o_Dir=10; tick -> o_Dir stays 10.
5. Priority and simultaneity:
   - From right, press up and left on the same cycle -> only up queued (count=1).
   - Then assert a tick in the same cycle as a down press -> o_Dir=00, down rejected against pre-pop tail up, count=0.
6. Reset mid-operation: with count=2 and i_Sw[1] mid-debounce, assert Reset 1 cycle -> count=0, o_Dir=11, the debounce counter is restarted and no press is generated afterwards unless the switch is still held for DEBOUNCE_LIMIT cycles.

Source files
------------

// File: rtl/snake_dir_ctrl.sv
// Switch conditioning for the snake game: two-flop sync, per-switch debounce,
// press detection, turn filtering and a 2-deep turn queue released on game ticks.
module snake_dir_ctrl #(
    parameter int         DEBOUNCE_LIMIT = 250000,
    parameter int         CNT_WIDTH      = 18,
    parameter logic [1:0] INIT_DIR       = 2'b11
) (
    input  logic       i_Clk,
    input  logic       Reset,
    input  logic [3:0] i_Sw,
    input  logic       i_Tick,
    output logic [1:0] o_Dir,
    output logic       o_Snake_Up,
    output logic       o_Snake_Down,
    output logic       o_Snake_Left,
    output logic       o_Snake_Right,
    output logic [3:0] o_Sw_Debounced,
    output logic [1:0] o_Queue_Count,
    output logic       o_Turn_Drop
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_LIMIT - 1);
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    logic [3:0] sync1_reg;
    logic [3:0] sync2_reg;
    logic [3:0] deb_level;
    logic [3:0] deb_prev_reg;
    logic [3:0] press_vec;

    always_ff @(posedge i_Clk) begin
        if (Reset) begin
            sync1_reg    <= 4'b0000;
            sync2_reg    <= 4'b0000;
            deb_prev_reg <= 4'b0000;
        end else begin
            sync1_reg    <= i_Sw;
            sync2_reg    <= sync1_reg;
            deb_prev_reg <= deb_level;
        end
    end

    // A level change is accepted only after DEBOUNCE_LIMIT consecutive mismatching cycles.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
            logic [CNT_WIDTH-1:0] cnt_reg;
            logic                 level_reg;

            always_ff @(posedge i_Clk) begin
                if (Reset) begin
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                end else if (sync2_reg[gi] != level_reg) begin
                    if (cnt_reg == CNT_LAST) begin
                        level_reg <= sync2_reg[gi];
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end else begin
                    cnt_reg <= '0;
                end
            end

            assign deb_level[gi] = level_reg;
        end
    endgenerate

    assign press_vec = deb_level & ~deb_prev_reg;

    logic       press_valid;
    logic [1:0] press_dir;

    always_comb begin
        press_valid = 1'b1;
        press_dir   = DIR_UP;
        if (press_vec[3])      press_dir = DIR_UP;
        else if (press_vec[0]) press_dir = DIR_DOWN;
        else if (press_vec[1]) press_dir = DIR_LEFT;
        else if (press_vec[2]) press_dir = DIR_RIGHT;
        else                   press_valid = 1'b0;
    end

    logic [1:0] dir_reg,    dir_next;
    logic [1:0] slot0_reg,  slot0_next;
    logic [1:0] slot1_reg,  slot1_next;
    logic [1:0] count_reg,  count_next;
    logic       drop_reg,   drop_next;
    logic [1:0] ref_dir;
    logic [1:0] slot_idx;
    logic       accept;
    logic       pop;
    logic       push;

    assign ref_dir = (count_reg == 2'd0) ? dir_reg :
                     ((count_reg == 2'd2) ? slot1_reg : slot0_reg);

    // Equal and opposite directions share the axis bit, so both are rejected by one compare.
    assign accept    = press_valid && (press_dir[1] != ref_dir[1]);
    assign pop       = i_Tick && (count_reg != 2'd0);
    assign push      = accept && ((count_reg != 2'd2) || pop);
    assign drop_next = accept && (count_reg == 2'd2) && !pop;
    assign slot_idx  = count_reg - {1'b0, pop};

    always_comb begin
        dir_next   = dir_reg;
        slot0_next = slot0_reg;
        slot1_next = slot1_reg;
        if (pop) begin
            dir_next   = slot0_reg;
            slot0_next = slot1_reg;
        end
        if (push) begin
            if (slot_idx == 2'd0) slot0_next = press_dir;
            else                  slot1_next = press_dir;
        end
        count_next = count_reg + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge i_Clk) begin
        if (Reset) begin
            dir_reg   <= INIT_DIR;
            slot0_reg <= 2'b00;
            slot1_reg <= 2'b00;
            count_reg <= 2'd0;
            drop_reg  <= 1'b0;
        end else begin
            dir_reg   <= dir_next;
            slot0_reg <= slot0_next;
            slot1_reg <= slot1_next;
            count_reg <= count_next;
            drop_reg  <= drop_next;
        end
    end

    assign o_Dir          = dir_reg;
    assign o_Snake_Up     = (dir_reg == DIR_UP);
    assign o_Snake_Down   = (dir_reg == DIR_DOWN);
    assign o_Snake_Left   = (dir_reg == DIR_LEFT);
    assign o_Snake_Right  = (dir_reg == DIR_RIGHT);
    assign o_Sw_Debounced = deb_level;
    assign o_Queue_Count  = count_reg;
    assign o_Turn_Drop    = drop_reg;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl: directed scenarios plus random switch/tick traffic,
// every cycle compared against a queue-based behavioural model.
module tb_snake_dir_ctrl;

    localparam int LIM = 4;

    logic       i_Clk  = 1'b0;
    logic       Reset  = 1'b1;
    logic [3:0] i_Sw   = 4'b0000;
    logic       i_Tick = 1'b0;
    logic [1:0] o_Dir;
    logic       o_Snake_Up, o_Snake_Down, o_Snake_Left, o_Snake_Right;
    logic [3:0] o_Sw_Debounced;
    logic [1:0] o_Queue_Count;
    logic       o_Turn_Drop;

    snake_dir_ctrl #(
        .DEBOUNCE_LIMIT(LIM),
        .CNT_WIDTH     (18),
        .INIT_DIR      (2'b11)
    ) dut (
        .i_Clk         (i_Clk),
        .Reset         (Reset),
        .i_Sw          (i_Sw),
        .i_Tick        (i_Tick),
        .o_Dir         (o_Dir),
        .o_Snake_Up    (o_Snake_Up),
        .o_Snake_Down  (o_Snake_Down),
        .o_Snake_Left  (o_Snake_Left),
        .o_Snake_Right (o_Snake_Right),
        .o_Sw_Debounced(o_Sw_Debounced),
        .o_Queue_Count (o_Queue_Count),
        .o_Turn_Drop   (o_Turn_Drop)
    );

    always #5 i_Clk = ~i_Clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // ---------------- behavioural model ----------------
    logic [1:0] m_dir   = 2'b11;
    logic [1:0] mq[$];
    logic [3:0] m_s1    = '0;
    logic [3:0] m_s2    = '0;
    logic [3:0] m_deb   = '0;
    logic [3:0] m_prev  = '0;
    logic [3:0] hist[$];
    logic       m_drop  = 1'b0;
    logic       m_valid = 1'b0;

    function automatic logic [1:0] opposite(input logic [1:0] d);
        case (d)
            2'b00:   return 2'b01;
            2'b01:   return 2'b00;
            2'b10:   return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] d);
        case (d)
            2'b00:   return 4'b1000;
            2'b01:   return 4'b0100;
            2'b10:   return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    task automatic model_step();
        logic [3:0] press;
        logic [3:0] new_deb;
        logic [1:0] pdir;
        logic [1:0] refd;
        logic       pv;
        logic       acc;
        logic       all_diff;
        cyc++;
        if (Reset) begin
            m_dir = 2'b11; mq.delete(); hist.delete();
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_prev = '0;
            m_drop = 1'b0; m_valid = 1'b1;
        end else begin
            press = m_deb & ~m_prev;
            pv = 1'b1; pdir = 2'b00;
            if (press[3])      pdir = 2'b00;
            else if (press[0]) pdir = 2'b01;
            else if (press[1]) pdir = 2'b10;
            else if (press[2]) pdir = 2'b11;
            else               pv = 1'b0;
            refd = (mq.size() > 0) ? mq[mq.size()-1] : m_dir;
            acc  = pv && (pdir != refd) && (pdir != opposite(refd));
            m_drop = 1'b0;
            if (i_Tick && mq.size() > 0) m_dir = mq.pop_front();
            if (acc) begin
                if (mq.size() < 2) mq.push_back(pdir);
                else               m_drop = 1'b1;
            end
            // debounced level flips once the last LIM synced samples all disagree with it
            hist.push_back(m_s2);
            if (hist.size() > LIM) void'(hist.pop_front());
            new_deb = m_deb;
            if (hist.size() == LIM) begin
                for (int b = 0; b < 4; b++) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < LIM; k++)
                        if (hist[k][b] == m_deb[b]) all_diff = 1'b0;
                    if (all_diff) new_deb[b] = ~m_deb[b];
                end
            end
            m_prev = m_deb;
            m_deb  = new_deb;
            m_s2   = m_s1;
            m_s1   = i_Sw;
        end
    endtask

    initial forever begin
        @(posedge i_Clk);
        model_step();
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int   drop_seen = 0;
    int   rise3     = 0;
    int   rise3_cyc = 0;
    logic prev3     = 1'b0;

    initial forever begin
        @(negedge i_Clk);
        if (m_valid) begin
            check("dir",    {6'd0, o_Dir}, {6'd0, m_dir});
            check("onehot", {4'd0, o_Snake_Up, o_Snake_Down, o_Snake_Left, o_Snake_Right},
                            {4'd0, onehot(m_dir)});
            check("deb",    {4'd0, o_Sw_Debounced}, {4'd0, m_deb});
            check("count",  {6'd0, o_Queue_Count}, 8'(mq.size()));
            check("drop",   {7'd0, o_Turn_Drop}, {7'd0, m_drop});
        end
        if (o_Turn_Drop) drop_seen++;
        if (o_Sw_Debounced[3] && !prev3) begin
            rise3++;
            rise3_cyc = cyc;
        end
        prev3 = o_Sw_Debounced[3];
    end

    // ---------------- stimulus ----------------
    task automatic wait_n(input int n);
        repeat (n) @(negedge i_Clk);
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b1;
        wait_n(n);
        Reset = 1'b0;
    endtask

    task automatic tap(input int idx);
        i_Sw[idx] = 1'b1;
        wait_n(LIM + 6);
        i_Sw[idx] = 1'b0;
        wait_n(LIM + 6);
    endtask

    task automatic tick();
        i_Tick = 1'b1;
        wait_n(1);
        i_Tick = 1'b0;
    endtask

    initial begin
        int base;
        // reset values
        do_reset(3);
        check("rst_dir",    {6'd0, o_Dir}, 8'h03);
        check("rst_onehot", {4'd0, o_Snake_Up, o_Snake_Down, o_Snake_Left, o_Snake_Right}, 8'h01);
        check("rst_count",  {6'd0, o_Queue_Count}, 8'h00);
        check("rst_deb",    {4'd0, o_Sw_Debounced}, 8'h00);
        check("rst_drop",   {7'd0, o_Turn_Drop}, 8'h00);

        // bouncing up switch, then a clean hold
        rise3 = 0;
        for (int i = 0; i < 10; i++) begin
            i_Sw[3] = ~i_Sw[3];
            wait_n(2);
        end
        base = cyc;
        i_Sw[3] = 1'b1;
        wait_n(12);
        check("bounce_rises",  8'(rise3), 8'd1);
        check("bounce_latency", 8'(rise3_cyc - base), 8'd6);
        check("bounce_count",  {6'd0, o_Queue_Count}, 8'd1);
        i_Sw[3] = 1'b0;
        wait_n(10);

        // reversal reject from right, then a legal turn
        do_reset(1);
        drop_seen = 0;
        tap(1);
        check("rev_left_count", {6'd0, o_Queue_Count}, 8'd0);
        check("rev_left_drop",  8'(drop_seen), 8'd0);
        tap(3);
        check("up_count", {6'd0, o_Queue_Count}, 8'd1);
        tick();
        check("up_tick_dir",   {6'd0, o_Dir}, 8'h00);
        check("up_tick_count", {6'd0, o_Queue_Count}, 8'd0);

        // fill queue, overflow, drain
        do_reset(1);
        drop_seen = 0;
        tap(3);
        tap(1);
        check("full_count", {6'd0, o_Queue_Count}, 8'd2);
        tap(0);
        check("overflow_drops", 8'(drop_seen), 8'd1);
        check("overflow_count", {6'd0, o_Queue_Count}, 8'd2);
        tick(); wait_n(1);
        check("drain1_dir", {6'd0, o_Dir}, 8'h00);
        tick(); wait_n(1);
        check("drain2_dir", {6'd0, o_Dir}, 8'h02);
        tick(); wait_n(1);
        check("drain3_dir", {6'd0, o_Dir}, 8'h02);

        // simultaneous presses, then tick coinciding with a press
        do_reset(1);
        drop_seen = 0;
        i_Sw[3] = 1'b1; i_Sw[1] = 1'b1;
        wait_n(10);
        i_Sw = 4'b0000;
        wait_n(10);
        check("prio_count", {6'd0, o_Queue_Count}, 8'd1);
        i_Sw[0] = 1'b1;
        wait_n(6);
        tick();
        wait_n(8);
        i_Sw[0] = 1'b0;
        wait_n(10);
        check("sim_dir",   {6'd0, o_Dir}, 8'h00);
        check("sim_count", {6'd0, o_Queue_Count}, 8'd0);
        check("sim_drop",  8'(drop_seen), 8'd0);

        // reset in the middle of a full queue and a debounce in progress
        do_reset(1);
        tap(3);
        tap(1);
        check("mid_full", {6'd0, o_Queue_Count}, 8'd2);
        i_Sw[1] = 1'b1;
        wait_n(4);
        Reset = 1'b1;
        wait_n(1);
        Reset = 1'b0;
        i_Sw[1] = 1'b0;
        check("mid_rst_count", {6'd0, o_Queue_Count}, 8'd0);
        check("mid_rst_dir",   {6'd0, o_Dir}, 8'h03);
        wait_n(12);
        check("mid_no_press", {4'd0, o_Sw_Debounced}, 8'h00);
        // a held switch restarts its full debounce after reset
        rise3 = 0;
        i_Sw[3] = 1'b1;
        wait_n(3);
        Reset = 1'b1;
        wait_n(1);
        Reset = 1'b0;
        base = cyc;
        wait_n(12);
        check("restart_rises",   8'(rise3), 8'd1);
        check("restart_latency", 8'(rise3_cyc - base), 8'd6);
        check("restart_count",   {6'd0, o_Queue_Count}, 8'd1);
        i_Sw[3] = 1'b0;
        wait_n(10);

        // random traffic
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 15))
                0, 1:    i_Sw = i_Sw ^ (4'b0001 << $urandom_range(0, 3));
                2:       i_Sw = 4'($urandom);
                default: ;
            endcase
            i_Tick = ($urandom_range(0, 11) == 0);
            Reset  = ($urandom_range(0, 599) == 0);
            wait_n(1);
        end
        Reset  = 1'b0;
        i_Tick = 1'b0;
        wait_n(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
